// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Holds the converter FSM encoding and the double-dabble digit constants.
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DIGIT_W = 4;

   // Digits at or above this value get +3 before each shift.
   localparam logic [DIGIT_W-1:0] ADD3_THRESH = 4'd5;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more
// so the following left shift carries correctly into the next decade.
module bcd_add3
   import bcd_pkg::*;
(
   input  logic [DIGIT_W-1:0] din,
   output logic [DIGIT_W-1:0] dout
);

   assign dout = (din >= ADD3_THRESH) ? din + DIGIT_W'(3) : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one bit per clock,
// with registered BCD digits and leading-zero blanking flags for the hex display.
module bin2bcd_seq
   import bcd_pkg::*;
#(
   parameter int N_BITS   = 10,
   parameter int N_DIGITS = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [N_BITS-1:0]           bin,
   output logic                        busy,
   output logic                        done,
   output logic [DIGIT_W*N_DIGITS-1:0] bcd,
   output logic [N_DIGITS-1:0]         lz_blank
);

   localparam int CNT_W  = $clog2(N_BITS + 1);
   localparam int WORK_W = DIGIT_W * N_DIGITS;
   localparam logic [N_DIGITS-1:0] LZ_RESET = {{(N_DIGITS-1){1'b1}}, 1'b0};
   localparam logic [CNT_W-1:0]    LAST_CNT = CNT_W'(N_BITS - 1);

   state_t                    state_reg;
   logic [N_BITS-1:0]         shift_reg;
   logic [WORK_W-1:0]         work_reg;
   logic [CNT_W-1:0]          cnt_reg;
   logic [WORK_W-1:0]         bcd_reg;
   logic [N_DIGITS-1:0]       lz_reg;
   logic                      busy_reg;
   logic                      done_reg;

   logic [WORK_W-1:0]         work_adj;
   logic [WORK_W+N_BITS-1:0]  dd_shifted;
   logic [WORK_W-1:0]         work_next;
   logic [N_BITS-1:0]         shift_next;
   logic [N_DIGITS-1:1]       digit_zero;
   logic [N_DIGITS-1:0]       lz_next;

   genvar gi;
   generate
      for (gi = 0; gi < N_DIGITS; gi++) begin : g_digit
         bcd_add3 u_add3 (
            .din  (work_reg[gi*DIGIT_W +: DIGIT_W]),
            .dout (work_adj[gi*DIGIT_W +: DIGIT_W])
         );

         // The ones digit always shows, even when the value is zero.
         if (gi == 0) begin : g_ones
            assign lz_next[gi] = 1'b0;
         end else begin : g_upper
            assign digit_zero[gi] = (work_next[gi*DIGIT_W +: DIGIT_W] == '0);
            assign lz_next[gi]    = &digit_zero[N_DIGITS-1:gi];
         end
      end
   endgenerate

   // The bit shifted out of the top digit is always zero for legal sizing.
   assign dd_shifted = {work_adj, shift_reg} << 1;
   assign work_next  = dd_shifted[WORK_W+N_BITS-1:N_BITS];
   assign shift_next = dd_shifted[N_BITS-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         shift_reg <= '0;
         work_reg  <= '0;
         cnt_reg   <= '0;
         bcd_reg   <= '0;
         lz_reg    <= LZ_RESET;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               done_reg <= 1'b0;
               if (start) begin
                  shift_reg <= bin;
                  work_reg  <= '0;
                  cnt_reg   <= '0;
                  busy_reg  <= 1'b1;
                  state_reg <= CONV;
               end
            end
            CONV: begin
               work_reg  <= work_next;
               shift_reg <= shift_next;
               cnt_reg   <= cnt_reg + CNT_W'(1);
               if (cnt_reg == LAST_CNT) begin
                  // Publish the finished digits on the same edge that enters DONE.
                  bcd_reg   <= work_next;
                  lz_reg    <= lz_next;
                  done_reg  <= 1'b1;
                  state_reg <= DONE;
               end
            end
            DONE: begin
               done_reg  <= 1'b0;
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
            default: begin
               done_reg  <= 1'b0;
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign busy     = busy_reg;
   assign done     = done_reg;
   assign bcd      = bcd_reg;
   assign lz_blank = lz_reg;

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 SHALL have parameter N_BITS, default 10, binary input width (matches the board's 10 slide switches).
REQ-002 SHALL have parameter N_DIGITS, default 4, BCD digit count; N_DIGITS SHALL satisfy 10^N_DIGITS > 2^N_BITS-1.
REQ-003 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  conversion request, sampled on clk.
REQ-006 SHALL have port bin  input  N_BITS  unsigned binary value, sampled when start is accepted.
REQ-007 SHALL have port busy  output  1  high whenever the block is not IDLE.
REQ-008 SHALL have port done  output  1  one-cycle pulse: new result valid.
REQ-009 SHALL have port bcd  output  4*N_DIGITS  packed digits; bits [3:0] = ones, next nibble = tens, and so on upward.
REQ-010 SHALL have port lz_blank  output  N_DIGITS  per digit, 1 = leading zero; the ones digit is never blanked.

Function
REQ-011 SHALL implement FSM states IDLE, CONV, DONE.
REQ-012 IDLE: start=1 at an edge SHALL load bin into the shift register, clear the BCD work register and the iteration counter, and go to CONV; start=0 SHALL keep IDLE.
REQ-013 CONV: each edge SHALL add 3 to every work digit >= 5, then shift {work,shift} left by 1, and increment the counter.
REQ-014 CONV SHALL last exactly N_BITS cycles; after the N_BITS-th shift the FSM SHALL go to DONE.
REQ-015 On entering DONE, bcd and lz_blank SHALL update from the work register at that same edge.
REQ-016 done SHALL equal (state==DONE): high for exactly one cycle, N_BITS+1 cycles after the accepting edge.
REQ-017 DONE SHALL go to IDLE unconditionally.
REQ-018 start SHALL be ignored while busy, including in the DONE cycle; the earliest accepted restart is the cycle after done.
REQ-019 bin changes after the accepting edge SHALL NOT affect the current conversion.
REQ-020 bcd and lz_blank SHALL hold their last values until the next DONE; they SHALL NOT glitch during CONV.
REQ-021 lz_blank[i] SHALL be 1 iff digit i and every higher digit are 0, for i >= 1; lz_blank[0] SHALL be 0.
REQ-022 The iteration counter SHALL be sized ceil(log2(N_BITS+1)) bits and SHALL NOT wrap within a conversion.
REQ-023 Every BCD digit SHALL remain in 0..9 for all inputs 0..2^N_BITS-1.

Reset
REQ-024 rst=1 SHALL asynchronously force state=IDLE, busy=0, done=0, bcd=0, lz_blank={N_DIGITS-1 ones, 0}, and clear the counter and work registers.
REQ-025 rst asserted mid-CONV SHALL abort the conversion with no done pulse; the output SHALL read 0 afterwards.
REQ-026 After rst deasserts, the first start SHALL be accepted on the first clk edge at which it is high.

Structure
REQ-027 A shared package bcd_pkg SHALL hold the state enum (IDLE/CONV/DONE), the digit width constant (4), and the add-3 threshold constant (5).
REQ-028 A sub-module bcd_add3 (4-bit in, 4-bit out, combinational: +3 if >= 5) SHALL be instantiated N_DIGITS times via generate.
REQ-029 The block SHALL sit upstream of the seven_seg_top hex decoders; its bcd nibbles feed HEX0..HEX3, and lz_blank drives digit blanking.

Verification
REQ-030 bin=0, start pulse -> done 11 cycles later, bcd=0x0000, lz_blank=4'b1110.
REQ-031 bin=1023 -> bcd=0x1023, lz_blank=4'b0000; bin=999 -> bcd=0x0999, lz_blank=4'b1000.
REQ-032 Exhaustive sweep of bin 0..1023, each followed by waiting for done -> bcd matches the decimal reference model; every digit <= 9.
REQ-033 bin=512 start, then start held high with bin=7 through CONV and DONE -> first done gives 0x0512; the conversion of 7 starts the cycle after done and yields 0x0007.
REQ-034 bin=345 start, rst pulsed at CONV cycle 5 -> no done, bcd=0, busy=0 immediately (async); a subsequent start with bin=8 -> 0x0008.
REQ-035 bin changed every cycle during CONV after start with bin=256 -> result 0x0256.
